// File: rtl/ov_stream_gen_if.sv
// Parallel camera bus between the synthetic stream generator and its consumer.
// The generator owns the master side: it reads the control inputs and drives
// the OV7670-style sync/data lines plus the completed-frame counter.
interface ov_stream_gen_if;
    logic        work_en;
    logic [1:0]  pattern_sel;
    logic        ov_vs;
    logic        ov_hs;
    logic [7:0]  cam_data;
    logic [15:0] frame_cnt;

    modport master (
        input  work_en,
        input  pattern_sel,
        output ov_vs,
        output ov_hs,
        output cam_data,
        output frame_cnt
    );

    modport slave (
        output work_en,
        output pattern_sel,
        input  ov_vs,
        input  ov_hs,
        input  cam_data,
        input  frame_cnt
    );
endinterface

// File: rtl/ov_stream_gen.sv
// Synthetic OV7670 transmitter: VGA YUV422 (YUYV) timing on the pixel clock.
// A row/column counter pair walks the whole frame. Sync, HREF and the pixel
// byte are decoded from the current position and registered, so every output
// lags the counters by one clock. Frames are only ever emitted whole.
module ov_stream_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic             ov_pclk,
    input  logic             rst,
    ov_stream_gen_if.master  bus
);

    localparam int LINE_CLK = 2 * (H_ACTIVE + H_BLANK);
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int ROW0     = V_SYNC + V_BACK;

    // One spare count of headroom so the exclusive upper bounds below always fit.
    localparam int CW = $clog2(LINE_CLK + 1);
    localparam int RW = $clog2(V_TOTAL + 1);

    localparam logic [CW-1:0] COL_LAST    = CW'(LINE_CLK - 1);
    localparam logic [CW-1:0] COL_ACT_END = CW'(2 * H_ACTIVE);
    localparam logic [RW-1:0] ROW_LAST    = RW'(V_TOTAL - 1);
    localparam logic [RW-1:0] ROW_VS_END  = RW'(V_SYNC);
    localparam logic [RW-1:0] ROW_ACT_BEG = RW'(ROW0);
    localparam logic [RW-1:0] ROW_ACT_END = RW'(ROW0 + V_ACTIVE);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   col_reg;
    logic [RW-1:0]   row_reg;
    logic [1:0]      pat_reg;
    logic            vs_reg;
    logic            hs_reg;
    logic [7:0]      data_reg;
    logic [15:0]     frame_cnt_reg;

    logic            in_run;
    logic            vs_next;
    logic            hs_next;
    logic [7:0]      data_next;
    logic [7:0]      x_lo;
    logic [7:0]      y_lo;
    logic [7:0]      y_byte;

    // Decode sync, HREF and the pattern byte for the current frame position.
    always_comb begin
        in_run  = (state_reg == ST_RUN);
        // Only the low byte of the pixel coordinates ever reaches the output.
        x_lo    = 8'(col_reg >> 1);
        y_lo    = 8'(row_reg) - 8'(ROW0);
        vs_next = in_run && (row_reg < ROW_VS_END);
        hs_next = in_run && (row_reg >= ROW_ACT_BEG) && (row_reg < ROW_ACT_END)
                         && (col_reg < COL_ACT_END);

        case (pat_reg)
            2'd0:    y_byte = x_lo;
            2'd1:    y_byte = y_lo;
            2'd3:    y_byte = (x_lo[3] ^ y_lo[3]) ? 8'hEB : 8'h10;
            default: y_byte = 8'(col_reg);
        endcase

        // Both chroma samples are neutral grey, so U and V need no x-parity select.
        data_next = 8'h00;
        if (hs_next) begin
            if (pat_reg == 2'd2) begin
                data_next = 8'(col_reg);
            end else begin
                data_next = col_reg[0] ? 8'h80 : y_byte;
            end
        end
    end

    // Frame sequencer: position counters, pattern latch, frame count and registered outputs.
    always_ff @(posedge ov_pclk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            row_reg       <= '0;
            col_reg       <= '0;
            pat_reg       <= 2'd0;
            vs_reg        <= 1'b0;
            hs_reg        <= 1'b0;
            data_reg      <= 8'h00;
            frame_cnt_reg <= 16'd0;
        end else begin
            vs_reg   <= vs_next;
            hs_reg   <= hs_next;
            data_reg <= data_next;

            case (state_reg)
                ST_IDLE: begin
                    row_reg <= '0;
                    col_reg <= '0;
                    if (bus.work_en) begin
                        state_reg <= ST_RUN;
                        pat_reg   <= bus.pattern_sel;
                    end
                end
                ST_RUN: begin
                    if (col_reg == COL_LAST) begin
                        col_reg <= '0;
                        if (row_reg == ROW_LAST) begin
                            // Frame boundary: the only place work_en and pattern_sel are honoured.
                            row_reg       <= '0;
                            frame_cnt_reg <= frame_cnt_reg + 16'd1;
                            if (bus.work_en) begin
                                pat_reg <= bus.pattern_sel;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            row_reg <= row_reg + RW'(1);
                        end
                    end else begin
                        col_reg <= col_reg + CW'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.ov_vs     = vs_reg;
    assign bus.ov_hs     = hs_reg;
    assign bus.cam_data  = data_reg;
    assign bus.frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_ov_stream_gen.sv
// Bench for ov_stream_gen: a small-geometry instance checked clock by clock
// against an expected-stream queue, and a default-geometry instance whose
// first active line is spot-checked.
module tb_ov_stream_gen;

    localparam int S_HA = 4;
    localparam int S_HB = 2;
    localparam int S_VS = 1;
    localparam int S_VB = 1;
    localparam int S_VA = 2;
    localparam int S_VF = 1;
    localparam int S_LC = 2 * (S_HA + S_HB);
    localparam int S_VT = S_VS + S_VB + S_VA + S_VF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;
    int exp_fc   = 0;

    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];

    ov_stream_gen_if bus();
    ov_stream_gen_if bus_big();

    ov_stream_gen #(
        .H_ACTIVE (S_HA),
        .H_BLANK  (S_HB),
        .V_SYNC   (S_VS),
        .V_BACK   (S_VB),
        .V_ACTIVE (S_VA),
        .V_FRONT  (S_VF)
    ) u_dut (
        .ov_pclk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    ov_stream_gen u_dut_big (
        .ov_pclk (clk),
        .rst     (rst),
        .bus     (bus_big)
    );

    always #5 clk = ~clk;

    // Expected {vs, hs, data} for one whole small frame, derived from line/pixel geometry.
    task automatic push_frame(input int p);
        for (int ln = 0; ln < S_VT; ln++) begin
            for (int c = 0; c < S_LC; c++) begin
                logic       v;
                logic       h;
                logic [7:0] d;
                int         px;
                int         yy;
                v = (ln < S_VS);
                h = (ln >= S_VS + S_VB) && (ln < S_VS + S_VB + S_VA) && (c < 2 * S_HA);
                d = 8'h00;
                if (h) begin
                    px = c / 2;
                    yy = ln - (S_VS + S_VB);
                    if (p == 2)          d = 8'(c);
                    else if (c % 2 == 1) d = 8'h80;
                    else if (p == 0)     d = 8'(px);
                    else if (p == 1)     d = 8'(yy);
                    else                 d = (((px / 8) % 2) != ((yy / 8) % 2)) ? 8'hEB : 8'h10;
                end
                exp_q.push_back({v, h, d});
            end
        end
        exp_fc++;
    endtask

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(10'h000);
    endtask

    // Advance n clocks, recording the outputs 1 ns after each rising edge.
    task automatic collect(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            obs_q.push_back({bus.ov_vs, bus.ov_hs, bus.cam_data});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.work_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        exp_fc = 0;
    endtask

    task automatic test_reset_hramp();
        logic [9:0] e, o;
        int idx, vs_cnt, hs_cnt;
        do_reset();
        checks++;
        if ({bus.ov_vs, bus.ov_hs, bus.cam_data} !== 10'h000 || bus.frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state got vs=%b hs=%b data=%h fc=%0d expected all 0",
                     bus.ov_vs, bus.ov_hs, bus.cam_data, bus.frame_cnt);
        end
        bus.pattern_sel = 2'd0;
        bus.work_en = 1'b1;
        push_idle(1);
        collect(1);
        bus.work_en = 1'b0;
        push_frame(0);
        collect(60);
        checks++;
        if (bus.frame_cnt !== 16'(exp_fc)) begin
            failures++;
            $display("FAIL hramp_fcnt got %0d expected %0d", bus.frame_cnt, exp_fc);
        end
        push_idle(3);
        collect(3);
        idx = 0; vs_cnt = 0; hs_cnt = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o[9]) vs_cnt++;
            if (o[8]) hs_cnt++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL hramp_stream idx=%0d got vs=%b hs=%b data=%h expected vs=%b hs=%b data=%h",
                         idx, o[9], o[8], o[7:0], e[9], e[8], e[7:0]);
            end
            idx++;
        end
        checks++;
        if (vs_cnt != S_VS * S_LC) begin
            failures++;
            $display("FAIL hramp_vs_len got %0d expected %0d", vs_cnt, S_VS * S_LC);
        end
        checks++;
        if (hs_cnt != S_VA * 2 * S_HA) begin
            failures++;
            $display("FAIL hramp_hs_total got %0d expected %0d", hs_cnt, S_VA * 2 * S_HA);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e, o;
        int idx;
        do_reset();
        bus.pattern_sel = 2'd2;
        bus.work_en = 1'b1;
        push_idle(1);
        collect(1);
        for (int f = 1; f <= 3; f++) begin
            if (f == 3) bus.work_en = 1'b0;
            push_frame(2);
            collect(60);
            checks++;
            if (bus.frame_cnt !== 16'(f)) begin
                failures++;
                $display("FAIL b2b_fcnt frame=%0d got %0d expected %0d", f, bus.frame_cnt, f);
            end
        end
        push_idle(2);
        collect(2);
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_stream idx=%0d got vs=%b hs=%b data=%h expected vs=%b hs=%b data=%h",
                         idx, o[9], o[8], o[7:0], e[9], e[8], e[7:0]);
            end
            idx++;
        end
    endtask

    task automatic test_stop_midframe();
        logic [9:0] e, o;
        int idx;
        bus.pattern_sel = 2'd0;
        bus.work_en = 1'b1;
        push_idle(1);
        collect(1);
        push_frame(0);
        collect(30);
        bus.work_en = 1'b0;
        collect(30);
        checks++;
        if (bus.frame_cnt !== 16'(exp_fc)) begin
            failures++;
            $display("FAIL stop_fcnt got %0d expected %0d", bus.frame_cnt, exp_fc);
        end
        push_idle(4);
        collect(4);
        bus.pattern_sel = 2'd1;
        bus.work_en = 1'b1;
        push_idle(1);
        collect(1);
        bus.work_en = 1'b0;
        push_frame(1);
        collect(60);
        push_idle(1);
        collect(1);
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stop_stream idx=%0d got vs=%b hs=%b data=%h expected vs=%b hs=%b data=%h",
                         idx, o[9], o[8], o[7:0], e[9], e[8], e[7:0]);
            end
            idx++;
        end
    endtask

    task automatic test_pattern_change();
        logic [9:0] e, o;
        int idx;
        bus.pattern_sel = 2'd0;
        bus.work_en = 1'b1;
        push_idle(1);
        collect(1);
        push_frame(0);
        collect(20);
        bus.pattern_sel = 2'd1;
        collect(40);
        push_frame(1);
        collect(1);
        bus.work_en = 1'b0;
        collect(59);
        push_idle(1);
        collect(1);
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL patchg_stream idx=%0d got vs=%b hs=%b data=%h expected vs=%b hs=%b data=%h",
                         idx, o[9], o[8], o[7:0], e[9], e[8], e[7:0]);
            end
            idx++;
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] e, o;
        int idx, vs_cnt;
        bus.pattern_sel = 2'd0;
        bus.work_en = 1'b1;
        push_idle(1);
        push_frame(0);
        // 28 samples end at line 2, column 2: inside HREF.
        collect(28);
        idx = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL arst_pre idx=%0d got vs=%b hs=%b data=%h expected vs=%b hs=%b data=%h",
                         idx, o[9], o[8], o[7:0], e[9], e[8], e[7:0]);
            end
            idx++;
        end
        exp_q.delete();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.ov_vs, bus.ov_hs, bus.cam_data} !== 10'h000 || bus.frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL arst_immediate got vs=%b hs=%b data=%h fc=%0d expected all 0",
                     bus.ov_vs, bus.ov_hs, bus.cam_data, bus.frame_cnt);
        end
        // work_en stays high through reset: reset must keep the block idle.
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({bus.ov_vs, bus.ov_hs, bus.cam_data} !== 10'h000) begin
            failures++;
            $display("FAIL arst_held got vs=%b hs=%b data=%h expected all 0",
                     bus.ov_vs, bus.ov_hs, bus.cam_data);
        end
        rst = 1'b0;
        exp_fc = 0;
        push_idle(1);
        collect(1);
        bus.work_en = 1'b0;
        push_frame(0);
        collect(60);
        checks++;
        if (bus.frame_cnt !== 16'(exp_fc)) begin
            failures++;
            $display("FAIL arst_fcnt got %0d expected %0d", bus.frame_cnt, exp_fc);
        end
        idx = 0; vs_cnt = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o[9]) vs_cnt++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL arst_post idx=%0d got vs=%b hs=%b data=%h expected vs=%b hs=%b data=%h",
                         idx, o[9], o[8], o[7:0], e[9], e[8], e[7:0]);
            end
            idx++;
        end
        checks++;
        if (vs_cnt != S_LC) begin
            failures++;
            $display("FAIL arst_vs_len got %0d expected %0d", vs_cnt, S_LC);
        end
    endtask

    task automatic test_default_checker();
        localparam int LC   = 2 * (640 + 144);
        localparam int R0   = 3 + 17;
        int   n, rise1, rise2, hs_len, vs_cnt;
        logic hs_prev;
        logic [7:0] b0, b1, b14, b16;
        rise1 = -1; rise2 = -1; hs_len = 0; vs_cnt = 0; hs_prev = 1'b0;
        b0 = 8'h00; b1 = 8'h00; b14 = 8'h00; b16 = 8'h00;
        bus_big.pattern_sel = 2'd3;
        bus_big.work_en = 1'b1;
        @(posedge clk); #1;
        bus_big.work_en = 1'b0;
        n = 0;
        while (n < 40000 && rise2 < 0) begin
            @(posedge clk); #1;
            n++;
            if (bus_big.ov_vs) vs_cnt++;
            if (bus_big.ov_hs && !hs_prev) begin
                if (rise1 < 0) rise1 = n;
                else rise2 = n;
            end
            if (rise1 > 0 && rise2 < 0 && bus_big.ov_hs) hs_len++;
            if (rise1 > 0) begin
                if (n == rise1)      b0  = bus_big.cam_data;
                if (n == rise1 + 1)  b1  = bus_big.cam_data;
                if (n == rise1 + 14) b14 = bus_big.cam_data;
                if (n == rise1 + 16) b16 = bus_big.cam_data;
            end
            hs_prev = bus_big.ov_hs;
        end
        checks++;
        if (rise2 < 0) begin
            failures++;
            $display("FAIL big_timeout got no second HREF within %0d clocks expected one", n);
        end
        checks++;
        if (vs_cnt != 3 * LC) begin
            failures++;
            $display("FAIL big_vs_len got %0d expected %0d", vs_cnt, 3 * LC);
        end
        checks++;
        if (rise1 != R0 * LC + 1) begin
            failures++;
            $display("FAIL big_first_href got %0d expected %0d", rise1, R0 * LC + 1);
        end
        checks++;
        if (hs_len != 1280) begin
            failures++;
            $display("FAIL big_href_len got %0d expected 1280", hs_len);
        end
        checks++;
        if (rise2 - rise1 != LC) begin
            failures++;
            $display("FAIL big_line_period got %0d expected %0d", rise2 - rise1, LC);
        end
        checks++;
        if (b0 !== 8'h10) begin
            failures++;
            $display("FAIL big_pix0_y got %h expected 10", b0);
        end
        checks++;
        if (b1 !== 8'h80) begin
            failures++;
            $display("FAIL big_pix0_u got %h expected 80", b1);
        end
        checks++;
        if (b14 !== 8'h10) begin
            failures++;
            $display("FAIL big_pix7_y got %h expected 10", b14);
        end
        checks++;
        if (b16 !== 8'hEB) begin
            failures++;
            $display("FAIL big_pix8_y got %h expected eb", b16);
        end
    endtask

    initial begin
        bus.work_en         = 1'b0;
        bus.pattern_sel     = 2'd0;
        bus_big.work_en     = 1'b0;
        bus_big.pattern_sel = 2'd0;
        test_reset_hramp();
        test_back_to_back();
        test_stop_midframe();
        test_pattern_change();
        test_async_reset();
        test_default_checker();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
